// File: rtl/calc_pkg.sv
// Shared constants, state type and channel-slice helper for the calculator result path.
package calc_pkg;

  localparam int CALC_WIDTH   = 8;
  localparam int CALC_NCH_MAX = 16;

  typedef enum logic {
    REG_EMPTY = 1'b0,
    REG_FULL  = 1'b1
  } reg_state_e;

  // Base bit position of channel ch inside a packed N x width bus.
  function automatic int unsigned sel_idx(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/calc_out_reg.sv
// Single-entry valid/ready pipeline register; the state encoding doubles as out_valid.
module calc_out_reg
  import calc_pkg::*;
#(
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [PW-1:0] pay_in,
  output logic [PW-1:0] pay_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          space
);

  reg_state_e state, state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= REG_EMPTY;
      pay_out <= '0;
    end else begin
      state <= state_nxt;
      if (load) pay_out <= pay_in;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      REG_EMPTY: if (load) state_nxt = REG_FULL;
      REG_FULL:  if (out_ready && !load) state_nxt = REG_EMPTY;
      default:   state_nxt = REG_EMPTY;
    endcase
  end

  assign out_valid = (state == REG_FULL);
  assign space     = (state == REG_EMPTY) || out_ready;

endmodule

// File: rtl/calc_result_mux.sv
// N-channel result selector with a registered valid/ready output stage.
module calc_result_mux
  import calc_pkg::*;
#(
  parameter  int WIDTH = CALC_WIDTH,
  parameter  int N_CH  = 2,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_flag,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  input  logic                  hold,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_flag,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel_err
);

  localparam int PW = 1 + SEL_W + WIDTH;

  logic             sel_ok;
  logic             space;
  logic             accept;
  logic [WIDTH-1:0] sel_data;
  logic             sel_flag;
  logic             sel_valid;
  logic [PW-1:0]    pay_out;

  // Widened compare so N_CH=16 (SEL_W=4) does not overflow the constant.
  assign sel_ok = ({1'b0, sel} < (SEL_W+1)'(N_CH));

  // Explicit per-channel match keeps out-of-range sel from indexing past the bus.
  always_comb begin
    sel_data  = '0;
    sel_flag  = 1'b0;
    sel_valid = 1'b0;
    in_ready  = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_data    = in_data[sel_idx(i, WIDTH) +: WIDTH];
        sel_flag    = in_flag[i];
        sel_valid   = in_valid[i];
        in_ready[i] = sel_ok && !hold && space;
      end
    end
  end

  assign accept = sel_valid && sel_ok && !hold && space;

  calc_out_reg #(
    .PW (PW)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .pay_in    ({sel_flag, sel, sel_data}),
    .pay_out   (pay_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .space     (space)
  );

  assign {out_flag, out_sel, out_data} = pay_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_err <= 1'b0;
    else        sel_err <= !sel_ok;
  end

endmodule

// File: tb/tb_calc_result_mux.sv
// Directed bench for calc_result_mux (WIDTH=8, N_CH=3) with a capture scoreboard.
module tb_calc_result_mux;

  localparam int W  = 8;
  localparam int NC = 3;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [SW-1:0] sel;
  logic [NC*W-1:0] in_data;
  logic [NC-1:0] in_flag;
  logic [NC-1:0] in_valid;
  logic [NC-1:0] in_ready;
  logic          hold;
  logic [W-1:0]  out_data;
  logic          out_flag;
  logic [SW-1:0] out_sel;
  logic          out_valid;
  logic          out_ready;
  logic          sel_err;

  logic [W-1:0]  ch_data [NC];

  int total = 0;
  int bad   = 0;

  logic [W+SW:0] q[$];
  logic          mv;
  logic [W-1:0]  last_data;
  logic [W+SW:0] exp_pl;

  always #5 clk = ~clk;

  assign in_data = {ch_data[2], ch_data[1], ch_data[0]};

  calc_result_mux #(
    .WIDTH (W),
    .N_CH  (NC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel       (sel),
    .in_data   (in_data),
    .in_flag   (in_flag),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .hold      (hold),
    .out_data  (out_data),
    .out_flag  (out_flag),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_err   (sel_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: pre-edge checks and scoreboard push/pop, edge, post-edge checks.
  task automatic tick();
    logic          exp_acc;
    logic [NC-1:0] exp_ir;
    logic          exp_se;
    logic [W+SW:0] popped;
    #1;
    exp_ir  = ((sel < NC) && !hold && (!mv || out_ready)) ? (NC'(1) << sel) : '0;
    exp_acc = (sel < NC) && in_valid[sel] && exp_ir[sel];
    exp_se  = (sel >= NC);
    chk("in_ready", 32'(in_ready), 32'(exp_ir));
    if (mv && out_ready) begin
      if (q.size() == 0) begin
        chk("pop_empty_queue", 32'(1), 32'(0));
      end else begin
        popped = q.pop_front();
        chk("pop_payload", 32'({out_flag, out_sel, out_data}), 32'(popped));
        last_data = popped[W-1:0];
      end
    end
    if (exp_acc) q.push_back({in_flag[sel], sel, ch_data[sel]});
    @(posedge clk);
    #1;
    if (exp_acc)            mv = 1'b1;
    else if (mv && out_ready) mv = 1'b0;
    chk("out_valid", 32'(out_valid), 32'(mv));
    chk("sel_err", 32'(sel_err), 32'(exp_se));
    if (mv) begin
      if (q.size() == 0) chk("held_entry_missing", 32'(1), 32'(0));
      else               chk("held_payload", 32'({out_flag, out_sel, out_data}), 32'(q[0]));
    end else begin
      chk("frozen_data", 32'(out_data), 32'(last_data));
    end
  endtask

  task automatic drive(input logic [SW-1:0] s, input logic [NC-1:0] v,
                       input logic [W-1:0] d, input logic f);
    sel = s;
    in_valid = v;
    if (s < NC) begin
      ch_data[s] = d;
      in_flag[s] = f;
    end
  endtask

  initial begin
    rst_n = 1'b0; sel = '0; in_flag = '0; in_valid = '0; hold = 1'b0; out_ready = 1'b0;
    for (int unsigned i = 0; i < NC; i++) ch_data[i] = 8'hE0 + W'(i);
    mv = 1'b0; last_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_data", 32'(out_data), 32'(0));
    chk("rst_out_flag", 32'(out_flag), 32'(0));
    chk("rst_out_sel", 32'(out_sel), 32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_sel_err", 32'(sel_err), 32'(0));
    rst_n = 1'b1;

    // Reset mid-transfer: load 0x5A, then pulse reset between edges.
    drive(2'd0, 3'b001, 8'h5A, 1'b1);
    tick();
    in_valid = '0;
    chk("pre_reset_data", 32'(out_data), 32'h5A);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_data", 32'(out_data), 32'(0));
    chk("async_rst_flag", 32'(out_flag), 32'(0));
    chk("async_rst_valid", 32'(out_valid), 32'(0));
    #1 rst_n = 1'b1;
    q.delete(); mv = 1'b0; last_data = '0;
    @(posedge clk); #1;

    // Basic select on channel 1.
    out_ready = 1'b1;
    drive(2'd1, 3'b010, 8'hA5, 1'b1);
    tick();
    chk("basic_data", 32'(out_data), 32'hA5);
    chk("basic_flag", 32'(out_flag), 32'(1));
    chk("basic_sel", 32'(out_sel), 32'(1));
    in_valid = '0;
    tick();

    // Backpressure: 0x11 held while 0x22 waits, then pop and load on one edge.
    out_ready = 1'b0;
    drive(2'd0, 3'b001, 8'h11, 1'b0);
    tick();
    drive(2'd0, 3'b001, 8'h22, 1'b1);
    tick();
    tick();
    chk("bp_stall_data", 32'(out_data), 32'h11);
    out_ready = 1'b1;
    tick();
    chk("bp_replace_data", 32'(out_data), 32'h22);
    in_valid = '0;
    tick();

    // Streaming 0x01..0x08 on channel 2.
    for (int unsigned k = 1; k <= 8; k++) begin
      drive(2'd2, 3'b100, W'(k), k[0]);
      tick();
      chk("stream_valid", 32'(out_valid), 32'(1));
    end
    in_valid = '0;
    tick();

    // Hold: drain the 0x3C entry while captures are blocked.
    out_ready = 1'b0;
    drive(2'd1, 3'b010, 8'h3C, 1'b0);
    tick();
    hold = 1'b1;
    drive(2'd1, 3'b010, 8'h77, 1'b1);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    chk("hold_frozen", 32'(out_data), 32'h3C);
    tick();
    hold = 1'b0;
    tick();
    out_ready = 1'b1;
    in_valid = '0;
    tick();

    // Illegal select for two cycles, then back to legal.
    drive(2'd3, 3'b111, 8'h00, 1'b0);
    tick();
    tick();
    drive(2'd0, 3'b000, 8'h99, 1'b0);
    tick();
    chk("illegal_no_capture", 32'(q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
